mem_port_arbiter: RTL

//  Shares the single synchronous memory port between the CPU (fetch/load/store, sequenced by the controller FSM)
//  and the display reader (VGA line fetch for the Tron playfield). One access per cycle; CPU has priority.
//  A starvation guard protects display reads, and display bursts hold the port for a bounded number of beats.

---
 rtl/tron_mem_pkg.sv | 16 +
 rtl/mem_arb_starve_ctr.sv | 27 ++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tron_mem_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding, read-data owner tags, counter widths.
package tron_mem_pkg;
  typedef enum logic {
    ARB       = 1'b0,
    VGA_BURST = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VGA  = 2'd2
  } owner_t;

  localparam int WAIT_CNT_W = 4;  // holds MAX_WAIT up to 15
  localparam int BEAT_W     = 4;  // holds BURST_LEN-1 up to 15
endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of cycles the display has waited for the port; sat raises display priority.
// No latency on sat (decoded from the register); clear wins over increment.
module mem_arb_starve_ctr
  import tron_mem_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  logic [WAIT_CNT_W-1:0] cnt;

  assign sat = (cnt >= WAIT_CNT_W'(MAX_WAIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + WAIT_CNT_W'(1);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one sync memory port between CPU (priority) and VGA reads with starvation guard and locked bursts.
// Grants are combinational, read data returns one cycle later; optional counters under ARB_STATS_EN.
module mem_port_arbiter
  import tron_mem_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 16,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_LEN = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [WIDTH-1:0]     cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_rvalid,
  output logic [WIDTH-1:0]     cpu_rdata,
  input  logic                 vga_req,
  input  logic                 vga_burst,
  input  logic [ADDR_BITS-1:0] vga_addr,
  output logic                 vga_gnt,
  output logic                 vga_rvalid,
  output logic [WIDTH-1:0]     vga_rdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 mem_we,
  input  logic [WIDTH-1:0]     mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]          stat_cpu_grants,
  output logic [15:0]          stat_vga_grants,
  output logic [15:0]          stat_conflicts
`endif
);
  arb_state_t        state, state_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_nxt;
  owner_t            owner, owner_nxt;
  logic              wait_sat;

  mem_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (vga_req & ~vga_gnt),
    .clr   (vga_gnt | ~vga_req),
    .sat   (wait_sat)
  );

  // Grants are gated by the reset level so every output reads 0 while reset is held.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    cpu_gnt   = 1'b0;
    vga_gnt   = 1'b0;
    if (reset) begin
      case (state)
        ARB: begin
          if (vga_req && (wait_sat || !cpu_req)) begin
            vga_gnt = 1'b1;
            if (vga_burst && (BURST_LEN > 1)) begin
              state_nxt = VGA_BURST;
              beat_nxt  = BEAT_W'(BURST_LEN - 1);
            end
          end else if (cpu_req) begin
            cpu_gnt = 1'b1;
          end
        end
        VGA_BURST: begin
          if (vga_req) begin
            vga_gnt  = 1'b1;
            beat_nxt = beat_cnt - BEAT_W'(1);
            if (beat_cnt == BEAT_W'(1)) begin
              state_nxt = ARB;
            end
          end else begin
            state_nxt = ARB;
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  always_comb begin
    mem_addr  = cpu_gnt ? cpu_addr : (vga_gnt ? vga_addr : '0);
    mem_we    = cpu_gnt & cpu_we;
    mem_wdata = mem_we ? cpu_wdata : '0;
    owner_nxt = vga_gnt ? OWN_VGA : ((cpu_gnt && !cpu_we) ? OWN_CPU : OWN_NONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ARB;
      beat_cnt <= '0;
      owner    <= OWN_NONE;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
      owner    <= owner_nxt;
    end
  end

  // The memory returns data for whichever access was granted last cycle; only its owner sees it.
  assign cpu_rvalid = (owner == OWN_CPU);
  assign vga_rvalid = (owner == OWN_VGA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign vga_rdata  = vga_rvalid ? mem_rdata : '0;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_cpu_grants <= '0;
      stat_vga_grants <= '0;
      stat_conflicts  <= '0;
    end else begin
      if (cpu_gnt && (stat_cpu_grants != 16'hFFFF)) stat_cpu_grants <= stat_cpu_grants + 16'd1;
      if (vga_gnt && (stat_vga_grants != 16'hFFFF)) stat_vga_grants <= stat_vga_grants + 16'd1;
      if (cpu_req && vga_req && (stat_conflicts != 16'hFFFF)) stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`endif
endmodule
